// File: rtl/exc_collector_pkg.sv
// Shared exception-code definitions for the collector and CP0.
// Both ends import this package so the code values always agree.
package exc_collector_pkg;

  localparam int EXC_CODE_W = 5;

  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  localparam exc_code_t EXC_INT  = 5'h00;
  localparam exc_code_t EXC_ADEL = 5'h04;
  localparam exc_code_t EXC_SYS  = 5'h08;
  localparam exc_code_t EXC_BP   = 5'h09;
  localparam exc_code_t EXC_RI   = 5'h0a;
  localparam exc_code_t EXC_OV   = 5'h0c;
  localparam exc_code_t EXC_NONE = 5'h10;
  localparam exc_code_t EXC_ERET = 5'h11;

  typedef struct packed {
    logic adel;
    logic ri;
    logic sys;
    logic bp;
    logic ov;
    logic eret;
  } exc_flags_t;

  function automatic logic is_exc(input exc_code_t code);
    return code != EXC_NONE;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// One pipeline way's exception flags reduced to a single code.
// Purely combinational; an invalid way always encodes NONE.
module exc_prio_enc
  import exc_collector_pkg::*;
(
  input  logic       valid_i,
  input  exc_flags_t flags_i,
  output exc_code_t  code_o
);

  always_comb begin
    code_o = EXC_NONE;
    if (valid_i) begin
      if (flags_i.adel)      code_o = EXC_ADEL;
      else if (flags_i.ri)   code_o = EXC_RI;
      else if (flags_i.sys)  code_o = EXC_SYS;
      else if (flags_i.bp)   code_o = EXC_BP;
      else if (flags_i.ov)   code_o = EXC_OV;
      else if (flags_i.eret) code_o = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_collector.sv
// Exception collector: encodes both EX ways, tracks delay slots across
// bundles and presents registered {code, pc, in_delay} to CP0.
module exc_collector
  import exc_collector_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int CODE_W = EXC_CODE_W
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [1:0]          ex_valid,
  input  logic [2*PC_W-1:0]   ex_pc,
  input  logic [1:0]          ex_adel,
  input  logic [1:0]          ex_ri,
  input  logic [1:0]          ex_sys,
  input  logic [1:0]          ex_bp,
  input  logic [1:0]          ex_ov,
  input  logic [1:0]          ex_eret,
  input  logic [1:0]          ex_branch,
  input  logic                ex_stall,
  input  logic                exc_flush_all,
  output logic [2*CODE_W-1:0] ex_cp0_exc_code_o,
  output logic [2*PC_W-1:0]   ex_cp0_exc_pc_o,
  output logic [1:0]          ex_cp0_in_delay_o
);

  localparam logic [2*CODE_W-1:0] CODE_RST = {2{CODE_W'(EXC_NONE)}};

  exc_flags_t [1:0] way_flags;
  exc_code_t  [1:0] way_code;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign way_flags[w] = '{adel: ex_adel[w], ri: ex_ri[w], sys: ex_sys[w],
                            bp: ex_bp[w], ov: ex_ov[w], eret: ex_eret[w]};

    exc_prio_enc u_enc (
      .valid_i (ex_valid[w]),
      .flags_i (way_flags[w]),
      .code_o  (way_code[w])
    );
  end

  logic [2*CODE_W-1:0] code_q, code_d, code_load;
  logic [2*PC_W-1:0]   pc_q, pc_d, pc_load;
  logic [1:0]          in_delay_q, in_delay_d, in_delay_load;
  logic                pend_ds_q, pend_ds_d, pend_ds_load;
  logic                way1_live;

  // The older instruction takes the exception; way1 is squashed behind it.
  always_comb begin
    way1_live = ex_valid[1] & ~is_exc(way_code[0]);

    code_load = {(way1_live ? CODE_W'(way_code[1]) : CODE_W'(EXC_NONE)),
                 CODE_W'(way_code[0])};

    pc_load = '0;
    if (ex_valid[0]) pc_load[PC_W-1:0]      = ex_pc[PC_W-1:0];
    if (way1_live)   pc_load[2*PC_W-1:PC_W] = ex_pc[2*PC_W-1:PC_W];

    in_delay_load[0] = ex_valid[0] & pend_ds_q;
    in_delay_load[1] = way1_live & (ex_valid[0] ? ex_branch[0] : pend_ds_q);
  end

  // Bubbles leave pend_ds alone so a delay slot survives empty bundles.
  always_comb begin
    pend_ds_load = pend_ds_q;
    if (way1_live)        pend_ds_load = ex_branch[1];
    else if (ex_valid[0]) pend_ds_load = ex_branch[0] & ~ex_valid[1];
  end

  always_comb begin
    code_d     = code_q;
    pc_d       = pc_q;
    in_delay_d = in_delay_q;
    pend_ds_d  = pend_ds_q;
    if (exc_flush_all) begin
      code_d     = CODE_RST;
      pc_d       = '0;
      in_delay_d = '0;
      pend_ds_d  = 1'b0;
    end else if (!ex_stall) begin
      code_d     = code_load;
      pc_d       = pc_load;
      in_delay_d = in_delay_load;
      pend_ds_d  = pend_ds_load;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      code_q     <= CODE_RST;
      pc_q       <= '0;
      in_delay_q <= '0;
      pend_ds_q  <= 1'b0;
    end else begin
      code_q     <= code_d;
      pc_q       <= pc_d;
      in_delay_q <= in_delay_d;
      pend_ds_q  <= pend_ds_d;
    end
  end

  assign ex_cp0_exc_code_o = code_q;
  assign ex_cp0_exc_pc_o   = pc_q;
  assign ex_cp0_in_delay_o = in_delay_q;

endmodule

// File: tb/tb_exc_collector.sv
// Self-checking bench for exc_collector: directed vector table, hand-written
// stall/flush/reset sequences, and random bundles against a reference model.
module tb_exc_collector;

  logic        clk;
  logic        rst_;
  logic [1:0]  ex_valid, ex_adel, ex_ri, ex_sys, ex_bp, ex_ov, ex_eret, ex_branch;
  logic [63:0] ex_pc;
  logic        ex_stall, exc_flush_all;
  logic [9:0]  ex_cp0_exc_code_o;
  logic [63:0] ex_cp0_exc_pc_o;
  logic [1:0]  ex_cp0_in_delay_o;

  int errors = 0;
  int checks = 0;

  exc_collector #(.PC_W(32), .CODE_W(5)) dut (
    .clk               (clk),
    .rst_              (rst_),
    .ex_valid          (ex_valid),
    .ex_pc             (ex_pc),
    .ex_adel           (ex_adel),
    .ex_ri             (ex_ri),
    .ex_sys            (ex_sys),
    .ex_bp             (ex_bp),
    .ex_ov             (ex_ov),
    .ex_eret           (ex_eret),
    .ex_branch         (ex_branch),
    .ex_stall          (ex_stall),
    .exc_flush_all     (exc_flush_all),
    .ex_cp0_exc_code_o (ex_cp0_exc_code_o),
    .ex_cp0_exc_pc_o   (ex_cp0_exc_pc_o),
    .ex_cp0_in_delay_o (ex_cp0_in_delay_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid, adel, ri, sys, bp, ov, eret, branch;
    logic        stall, flush;
    logic [63:0] pc;
    logic [9:0]  exp_code;
    logic [63:0] exp_pc;
    logic [1:0]  exp_dly;
  } vec_t;

  // Reference model: architectural view of what CP0 should see.
  logic [9:0]  m_code;
  logic [63:0] m_pc;
  logic [1:0]  m_dly;
  logic        m_pend;

  function automatic logic [4:0] refCode(input logic v, adel, ri, sys, bp, ov, eret);
    if (!v)   return 5'h10;
    if (adel) return 5'h04;
    if (ri)   return 5'h0a;
    if (sys)  return 5'h08;
    if (bp)   return 5'h09;
    if (ov)   return 5'h0c;
    if (eret) return 5'h11;
    return 5'h10;
  endfunction

  task automatic modelReset();
    m_code = 10'h210;
    m_pc   = 64'h0;
    m_dly  = 2'b00;
    m_pend = 1'b0;
  endtask

  task automatic modelStep();
    logic [4:0] c0, c1;
    logic       live1;
    if (exc_flush_all) begin
      modelReset();
    end else if (!ex_stall) begin
      c0 = refCode(ex_valid[0], ex_adel[0], ex_ri[0], ex_sys[0], ex_bp[0], ex_ov[0], ex_eret[0]);
      c1 = refCode(ex_valid[1], ex_adel[1], ex_ri[1], ex_sys[1], ex_bp[1], ex_ov[1], ex_eret[1]);
      live1 = ex_valid[1] && (c0 == 5'h10);
      m_code = {(live1 ? c1 : 5'h10), c0};
      m_pc   = {(live1 ? ex_pc[63:32] : 32'h0), (ex_valid[0] ? ex_pc[31:0] : 32'h0)};
      m_dly[0] = ex_valid[0] && m_pend;
      m_dly[1] = live1 && (ex_valid[0] ? ex_branch[0] : m_pend);
      if (live1)            m_pend = ex_branch[1];
      else if (ex_valid[0]) m_pend = ex_branch[0] && !ex_valid[1];
    end
  endtask

  function automatic vec_t mkVec(input logic [1:0] valid, input logic [31:0] pc1, pc0,
                                 input logic [1:0] adel, ri, sys, bp, ov, eret, branch,
                                 input logic stall, flush, input logic [9:0] exp_code,
                                 input logic [31:0] epc1, epc0, input logic [1:0] exp_dly);
    vec_t v;
    v.valid = valid; v.pc = {pc1, pc0};
    v.adel = adel; v.ri = ri; v.sys = sys; v.bp = bp; v.ov = ov; v.eret = eret;
    v.branch = branch; v.stall = stall; v.flush = flush;
    v.exp_code = exp_code; v.exp_pc = {epc1, epc0}; v.exp_dly = exp_dly;
    return v;
  endfunction

  // Drive one bundle, advance the model, clock it in and settle past the edge.
  task automatic applyStimulus(input vec_t v);
    ex_valid = v.valid; ex_pc = v.pc;
    ex_adel = v.adel; ex_ri = v.ri; ex_sys = v.sys; ex_bp = v.bp;
    ex_ov = v.ov; ex_eret = v.eret; ex_branch = v.branch;
    ex_stall = v.stall; exc_flush_all = v.flush;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] code,
                             input logic [63:0] pc, input logic [1:0] dly);
    checks++;
    if (ex_cp0_exc_code_o !== code) begin
      errors++;
      $display("[TB] FAIL %s code: got %h want %h", name, ex_cp0_exc_code_o, code);
    end
    checks++;
    if (ex_cp0_exc_pc_o !== pc) begin
      errors++;
      $display("[TB] FAIL %s pc: got %h want %h", name, ex_cp0_exc_pc_o, pc);
    end
    checks++;
    if (ex_cp0_in_delay_o !== dly) begin
      errors++;
      $display("[TB] FAIL %s in_delay: got %b want %b", name, ex_cp0_in_delay_o, dly);
    end
  endtask

  function automatic logic [1:0] rndFlag2(input int oneIn);
    return {($urandom_range(oneIn - 1) == 0), ($urandom_range(oneIn - 1) == 0)};
  endfunction

  vec_t vecs[9];
  vec_t v;

  initial begin
    // valid, pc1, pc0, adel, ri, sys, bp, ov, eret, branch, stall, flush, code, epc1, epc0, dly
    vecs[0] = mkVec(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,
                    10'h210, 32'h0, 32'h0, 2'b00);
    vecs[1] = mkVec(2'b11, 32'hbfc00104, 32'hbfc00100, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0,
                    10'h208, 32'h0, 32'hbfc00100, 2'b00);
    vecs[2] = mkVec(2'b11, 32'hbfc00204, 32'hbfc00200, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0,
                    10'h210, 32'hbfc00204, 32'hbfc00200, 2'b00);
    vecs[3] = mkVec(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,
                    10'h210, 32'h0, 32'h0, 2'b00);
    vecs[4] = mkVec(2'b01, 32'h0, 32'hbfc00208, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,
                    10'h20a, 32'h0, 32'hbfc00208, 2'b01);
    vecs[5] = mkVec(2'b11, 32'hbfc0030c, 32'hbfc00308, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0,
                    10'h190, 32'hbfc0030c, 32'hbfc00308, 2'b10);
    vecs[6] = mkVec(2'b10, 32'hbfc00404, 32'hbfc00400, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0,
                    10'h090, 32'hbfc00404, 32'h0, 2'b00);
    vecs[7] = mkVec(2'b11, 32'hbfc00414, 32'hbfc00410, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 0, 0,
                    10'h209, 32'h0, 32'hbfc00410, 2'b00);
    vecs[8] = mkVec(2'b11, 32'hbfc00424, 32'hbfc00420, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0,
                    10'h230, 32'hbfc00424, 32'hbfc00420, 2'b00);

    rst_ = 1'b0;
    v = vecs[0];
    ex_valid = 0; ex_pc = 0; ex_adel = 0; ex_ri = 0; ex_sys = 0; ex_bp = 0;
    ex_ov = 0; ex_eret = 0; ex_branch = 0; ex_stall = 0; exc_flush_all = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_held", 10'h210, 64'h0, 2'b00);
    @(negedge clk);
    rst_ = 1'b1;
    applyStimulus(vecs[0]);
    checkOutput("reset_release", 10'h210, 64'h0, 2'b00);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_code, vecs[i].exp_pc, vecs[i].exp_dly);
    end

    // Exception with a pending way1 branch, then held by stall, then flushed.
    applyStimulus(mkVec(2'b11, 32'hbfc00504, 32'hbfc00500, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00,
                        2'b10, 0, 0, 10'h0, 32'h0, 32'h0, 2'b00));
    checkOutput("stall_load", 10'h150, {32'hbfc00504, 32'hbfc00500}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkVec(2'b11, 32'h12345678, 32'h9abcdef0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                          2'b11, 1, 0, 10'h0, 32'h0, 32'h0, 2'b00));
      checkOutput($sformatf("stall_hold%0d", i), 10'h150, {32'hbfc00504, 32'hbfc00500}, 2'b00);
    end
    applyStimulus(mkVec(2'b11, 32'h12345678, 32'h9abcdef0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                        2'b11, 1, 1, 10'h0, 32'h0, 32'h0, 2'b00));
    checkOutput("flush_with_stall", 10'h210, 64'h0, 2'b00);
    applyStimulus(mkVec(2'b01, 32'h0, 32'hbfc00600, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                        2'b00, 0, 0, 10'h0, 32'h0, 32'h0, 2'b00));
    checkOutput("pend_cleared", 10'h210, {32'h0, 32'hbfc00600}, 2'b00);

    // Asynchronous reset between edges clears outputs without a clock.
    applyStimulus(mkVec(2'b01, 32'h0, 32'hbfc00700, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                        2'b01, 0, 0, 10'h0, 32'h0, 32'h0, 2'b00));
    checkOutput("pre_async_reset", 10'h204, {32'h0, 32'hbfc00700}, 2'b00);
    #2 rst_ = 1'b0;
    #1;
    checkOutput("async_reset", 10'h210, 64'h0, 2'b00);
    modelReset();
    @(negedge clk);
    rst_ = 1'b1;

    for (int i = 0; i < 400; i++) begin
      v.valid  = 2'($urandom_range(3));
      v.pc     = {$urandom(), $urandom()} & 64'hfffffffc_fffffffc;
      v.adel   = rndFlag2(12);
      v.ri     = rndFlag2(10);
      v.sys    = rndFlag2(10);
      v.bp     = rndFlag2(10);
      v.ov     = rndFlag2(8);
      v.eret   = rndFlag2(10);
      v.branch = rndFlag2(3);
      v.stall  = ($urandom_range(7) == 0);
      v.flush  = ($urandom_range(9) == 0);
      applyStimulus(v);
      checkOutput("rand", m_code, m_pc, m_dly);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/exc_collector.md
# exc_collector

Exception collector for the dual-issue pipeline: the issuing end of the CP0 exception interface. Every cycle it samples both ways of the bundle leaving EX: valid bits, PCs, decode-time exception flags and ALU overflow. Per way it priority-encodes one 5-bit exception code, tracks branch delay slots across bundles, and drives registered `{code, pc, in_delay}` into CP0. CP0 evaluates them one cycle later and answers with `exc_flush_all`.

## Interface
Parameters:
- `PC_W`, 32, width of one way's PC
- `CODE_W`, 5, exception code width per way

Ports (way 0 = older instruction, in bits [lo]; way 1 in bits [hi]):
- `clk`  in  1  single clock, rising edge
- `rst_`  in  1  asynchronous, active-low reset
- `ex_valid`  in  2  way holds a real instruction
- `ex_pc`  in  2*PC_W  way PCs, {way1, way0}
- `ex_adel`  in  2  fetch address error
- `ex_ri`  in  2  reserved instruction
- `ex_sys`  in  2  SYSCALL
- `ex_bp`  in  2  BREAK
- `ex_ov`  in  2  ALU overflow, combinational from EX
- `ex_eret`  in  2  ERET
- `ex_branch`  in  2  branch/jump, so the next instruction is a delay slot
- `ex_stall`  in  1  hold the bundle
- `exc_flush_all`  in  1  flush from CP0
- `ex_cp0_exc_code_o`  out  2*CODE_W  {way1, way0} codes
- `ex_cp0_exc_pc_o`  out  2*PC_W  {way1, way0} PCs
- `ex_cp0_in_delay_o`  out  2  way is in a delay slot

## Operation
- Codes: INT 5'h00, ADEL 5'h04, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c, NONE 5'h10, ERET 5'h11. INT is never produced here.
- Per-way priority, highest first: ADEL > RI > SYS > BP > OV > ERET > NONE.
- An invalid way encodes NONE, with pc 0 and in_delay 0.
- Older wins: if way0 encodes anything other than NONE, way1 is forced to NONE, pc 0, in_delay 0.
- Delay-slot state register `pend_ds` means the next valid instruction is a delay slot.
  - way0 in_delay = `ex_valid[0] & pend_ds`.
  - way1 in_delay = `ex_valid[1] & (ex_valid[0] ? ex_branch[0] : pend_ds)`.
- `pend_ds` update on an accepted bundle (no stall, no flush):
  - If way1 is valid and unmasked: `pend_ds <= ex_branch[1]`.
  - Else if way0 is valid: `pend_ds <= ex_branch[0] & ~ex_valid[1]`.
  - Else: hold.
- The PC reported for a delay-slot instruction is its own PC. CP0 performs the −4.
- Update priority per cycle: flush > stall > load.
  - **Flush:** all outputs return to reset values and `pend_ds` clears. The current inputs are discarded.
  - **Stall:** outputs and `pend_ds` hold.
  - **Load:** the encoded bundle is registered.

## Timing
- Reset (async, immediate):
  - `ex_cp0_exc_code_o` = 10'h210 (NONE, NONE)
  - `ex_cp0_exc_pc_o` = 0
  - `ex_cp0_in_delay_o` = 0
  - `pend_ds` = 0
- Latency: inputs sampled at edge n appear on outputs after edge n; all outputs are registered.
- CP0 raises `exc_flush_all` combinationally in cycle n+1. At edge n+2 the block clears, so an exception is presented for exactly one cycle.
- Flush arriving with a stall: flush wins.
- A reset mid-bundle loses that bundle. There is no pending state except `pend_ds`, which resets to 0.
- A bundle with both ways invalid leaves `pend_ds` untouched, so a delay slot survives bubbles.
- A branch in way1 carries the delay slot into way0 of the next valid bundle.

## Structure
- Put the EXC_* code constants and `EXC_CODE_W` in the shared header beside the CP0 macros, so both ends agree.
- Sub-module `exc_prio_enc`: purely combinational, one way's flags to a code, instantiated twice.
- The top level holds the masking, delay-slot logic, `pend_ds` and the output registers.

## Test plan
- **Reset release:** with `rst_` low, outputs read code 10'h210, pc 0, in_delay 0. After release with idle inputs, they are unchanged.
- **SYSCALL + overflow:** way0 valid SYSCALL at pc 0xbfc00100, way1 valid OV -> next cycle code {NONE,SYS} = 10'h208, pc = {0, 0xbfc00100}.
- **Delay slot across bundles:**
  - way1 branch at 0xbfc00204 -> next valid way0 RI at 0xbfc00208 reports code 5'h0a, in_delay[0] = 1.
  - An intervening all-invalid bubble does not clear this.
- **Delay slot within a bundle:** way0 branch, way1 OV at 0xbfc0030c -> code {OV,NONE} = 10'h190, in_delay = 2'b10, pc[63:32] = 0xbfc0030c.
- **Stall then flush:**
  - Exception registered, then `ex_stall` high for 3 cycles: outputs hold.
  - `exc_flush_all` pulsed together with stall: outputs return to 10'h210 after the edge and `pend_ds` clears.
- **Priority and async reset:** one way with ADEL+RI+ERET set encodes 5'h04. Asserting `rst_` low between clock edges clears outputs immediately.
